// File: rtl/change_dispenser.sv
// Change dispenser: pays a change amount greedily from 5/2/1 coin hoppers,
// one coin at a time over a fire/ack handshake, tracking per-coin inventory.
module change_dispenser #(
    parameter int CHANGE_W     = 4,
    parameter int CNT_W        = 8,
    parameter int INIT_CNT     = 20,
    parameter int PULSE_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CHANGE_W-1:0] change_amt,
    output logic                busy,
    output logic                done,
    output logic                shortfall,
    output logic [CHANGE_W-1:0] shortfall_amt,
    output logic                fault,
    output logic [1:0]          hopper_sel,
    output logic                hopper_fire,
    input  logic                hopper_ack,
    input  logic                refill,
    input  logic [1:0]          refill_sel,
    input  logic [CNT_W-1:0]    refill_qty,
    output logic [CNT_W-1:0]    inv5,
    output logic [CNT_W-1:0]    inv2,
    output logic [CNT_W-1:0]    inv1
);

    localparam int MAX_CYC = (ACK_TIMEOUT > PULSE_CYCLES) ? ACK_TIMEOUT : PULSE_CYCLES;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_FIRE,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CHANGE_W-1:0] rem_q, rem_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                shortfall_q, shortfall_d;
    logic [CHANGE_W-1:0] sf_amt_q, sf_amt_d;
    logic                fault_q, fault_d;
    logic [1:0]          sel_q, sel_d;
    logic                fire_q, fire_d;

    // Inventory indexed by the hopper_sel code: 1 = coin 1, 2 = coin 2, 3 = coin 5.
    logic [CNT_W-1:0]    inv_q   [1:3];
    logic [CNT_W-1:0]    inv_d   [1:3];
    logic [CNT_W:0]      inv_sum [1:3];
    logic [3:1]          dec;
    logic [3:1]          zap;

    function automatic logic [CHANGE_W-1:0] coin_val(input logic [1:0] s);
        case (s)
            2'd1:    return CHANGE_W'(1);
            2'd2:    return CHANGE_W'(2);
            2'd3:    return CHANGE_W'(5);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        cyc_d       = cyc_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        shortfall_d = shortfall_q;
        sf_amt_d    = sf_amt_q;
        fault_d     = fault_q;
        sel_d       = sel_q;
        fire_d      = fire_q;
        dec         = '0;
        zap         = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d       = change_amt;
                    shortfall_d = 1'b0;
                    sf_amt_d    = '0;
                    busy_d      = 1'b1;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                // Greedy pick; a zero selection means either paid out or stuck.
                sel_d = 2'd0;
                if (rem_q != '0) begin
                    if (rem_q >= CHANGE_W'(5) && inv_q[3] != '0)      sel_d = 2'd3;
                    else if (rem_q >= CHANGE_W'(2) && inv_q[2] != '0) sel_d = 2'd2;
                    else if (inv_q[1] != '0)                          sel_d = 2'd1;
                    else begin
                        shortfall_d = 1'b1;
                        sf_amt_d    = rem_q;
                    end
                end
                if (sel_d != 2'd0) begin
                    cyc_d   = '0;
                    fire_d  = 1'b1;
                    state_d = S_FIRE;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_FIRE: begin
                if (cyc_q == CYC_W'(PULSE_CYCLES - 1)) begin
                    fire_d  = 1'b0;
                    cyc_d   = '0;
                    state_d = S_WAIT_ACK;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (hopper_ack) begin
                    rem_d      = rem_q - coin_val(sel_q);
                    dec[sel_q] = 1'b1;
                    state_d    = S_SELECT;
                end else if (cyc_q == CYC_W'(ACK_TIMEOUT - 1)) begin
                    // Silent hopper is written off so the next SELECT falls back to smaller coins.
                    zap[sel_q] = 1'b1;
                    fault_d    = 1'b1;
                    state_d    = S_SELECT;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 1; i <= 3; i++) begin
            inv_sum[i] = {1'b0, inv_q[i]} - {{CNT_W{1'b0}}, dec[i]}
                       + ((refill && refill_sel == 2'(i)) ? {1'b0, refill_qty} : '0);
            if (zap[i])                 inv_d[i] = '0;
            else if (inv_sum[i][CNT_W]) inv_d[i] = '1;
            else                        inv_d[i] = inv_sum[i][CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            cyc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            shortfall_q <= 1'b0;
            sf_amt_q    <= '0;
            fault_q     <= 1'b0;
            sel_q       <= 2'd0;
            fire_q      <= 1'b0;
            for (int i = 1; i <= 3; i++) inv_q[i] <= CNT_W'(INIT_CNT);
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            cyc_q       <= cyc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            shortfall_q <= shortfall_d;
            sf_amt_q    <= sf_amt_d;
            fault_q     <= fault_d;
            sel_q       <= sel_d;
            fire_q      <= fire_d;
            for (int i = 1; i <= 3; i++) inv_q[i] <= inv_d[i];
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign shortfall     = shortfall_q;
    assign shortfall_amt = sf_amt_q;
    assign fault         = fault_q;
    assign hopper_sel    = sel_q;
    assign hopper_fire   = fire_q;
    assign inv5          = inv_q[3];
    assign inv2          = inv_q[2];
    assign inv1          = inv_q[1];

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a single process drives payouts, plays the hopper
// (acks or stays silent) and compares against a greedy coin model.
module tb_change_dispenser;

    localparam int PULSE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] change_amt;
    logic       busy, done, shortfall, fault, hopper_fire, hopper_ack, refill;
    logic [3:0] shortfall_amt;
    logic [1:0] hopper_sel, refill_sel;
    logic [7:0] refill_qty, inv5, inv2, inv1;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk(clk), .rst_n(rst_n), .start(start), .change_amt(change_amt),
        .busy(busy), .done(done), .shortfall(shortfall), .shortfall_amt(shortfall_amt),
        .fault(fault), .hopper_sel(hopper_sel), .hopper_fire(hopper_fire),
        .hopper_ack(hopper_ack), .refill(refill), .refill_sel(refill_sel),
        .refill_qty(refill_qty), .inv5(inv5), .inv2(inv2), .inv1(inv1)
    );

    int checks = 0;
    int failures = 0;

    // Model state, indexed by hopper code (1 -> coin 1, 2 -> coin 2, 3 -> coin 5).
    int m_inv[4];
    bit m_fault;
    int val[4] = '{0, 1, 2, 5};
    int exp_att[$];
    int exp_sf;

    // Observations from the last payout.
    int obs_sel[$];
    int bad_w, sel_changes, done_cyc, first_fire, sf_obs, sfa_obs;
    bit got_done, busy1, busy_at_done, done_after;

    function automatic string seq_str(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Greedy payout in coin values; a jammed hopper gets one attempt, then counts as empty.
    task automatic model_payout(input int amt, input bit [3:0] jam, input int rq);
        int rem = amt;
        exp_att.delete();
        exp_sf = 0;
        while (rem > 0) begin
            int d = 0;
            for (int s = 3; s >= 1; s--)
                if (d == 0 && val[s] <= rem && m_inv[s] > 0) d = s;
            if (d == 0) begin
                exp_sf = rem;
                break;
            end
            exp_att.push_back(d);
            if (jam[d]) begin
                m_inv[d] = 0;
                m_fault  = 1'b1;
            end else begin
                m_inv[d] = sat(m_inv[d] - 1 + ((d == 2) ? rq : 0));
                rem -= val[d];
            end
        end
    endtask

    task automatic do_refill(input int sel, input int qty);
        @(negedge clk);
        refill = 1'b1; refill_sel = 2'(sel); refill_qty = 8'(qty);
        @(negedge clk);
        refill = 1'b0;
        if (sel != 0) m_inv[sel] = sat(m_inv[sel] + qty);
    endtask

    // Start a payout and act as the hopper until done (or budget expires).
    task automatic run_payout(input int amt, input bit [3:0] jam, input int ack_dly,
                              input int rq, input bit poke, input int budget);
        int c = 0, w = 0, ack_cnt = 0, cur = 0;
        bit pf = 1'b0;
        obs_sel.delete();
        bad_w = 0; sel_changes = 0; done_cyc = -1; first_fire = -1;
        got_done = 1'b0; busy1 = 1'b0; busy_at_done = 1'b1; sf_obs = -1; sfa_obs = -1;
        @(negedge clk);
        start = 1'b1; change_amt = 4'(amt);
        @(negedge clk);
        start = 1'b0; c = 1;
        while (!got_done && c < budget) begin
            hopper_ack = 1'b0; refill = 1'b0;
            if (hopper_fire) begin
                if (!pf) begin
                    obs_sel.push_back(int'(hopper_sel));
                    cur = hopper_sel; w = 1;
                    if (first_fire < 0) first_fire = c;
                end else begin
                    w++;
                    if (int'(hopper_sel) != cur) sel_changes++;
                end
            end else if (pf) begin
                if (w != PULSE) bad_w++;
                ack_cnt = ack_dly;
            end else if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0 && !jam[cur]) begin
                    hopper_ack = 1'b1;
                    if (rq > 0 && cur == 2) begin
                        refill = 1'b1; refill_sel = 2'd2; refill_qty = 8'(rq);
                    end
                end
            end
            // A start while busy must be ignored.
            start = poke && (c == 5);
            if (poke && c == 5) change_amt = 4'hF;
            if (c == 1) busy1 = busy;
            if (done) begin
                got_done = 1'b1; done_cyc = c; busy_at_done = busy;
                sf_obs = shortfall; sfa_obs = shortfall_amt;
            end
            pf = hopper_fire;
            @(negedge clk);
            c++;
        end
        start = 1'b0; hopper_ack = 1'b0; refill = 1'b0;
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; change_amt = '0; hopper_ack = 1'b0;
        refill = 1'b0; refill_sel = '0; refill_qty = '0;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, shortfall, fault, hopper_fire} !== 5'b0) begin
            failures++; $display("FAIL reset_flags: got %b want 00000", {busy, done, shortfall, fault, hopper_fire}); end
        checks++; if ({hopper_sel, shortfall_amt} !== 6'b0) begin
            failures++; $display("FAIL reset_sel_amt: got %0d/%0d want 0/0", hopper_sel, shortfall_amt); end
        checks++; if ({inv5, inv2, inv1} !== {8'd20, 8'd20, 8'd20}) begin
            failures++; $display("FAIL reset_inv: got %0d %0d %0d want 20 20 20", inv5, inv2, inv1); end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 3; i++) m_inv[i] = 20;
        m_fault = 1'b0;
    endtask

    task automatic test_basic();
        model_payout(8, 4'b0, 0);
        run_payout(8, 4'b0, 2, 0, 1'b0, 400);
        checks++; if (seq_str(obs_sel) != seq_str(exp_att)) begin
            failures++; $display("FAIL basic_seq: got %s want %s", seq_str(obs_sel), seq_str(exp_att)); end
        checks++; if (seq_str(obs_sel) != "3 2 1 ") begin
            failures++; $display("FAIL basic_seq_const: got %s want 3 2 1", seq_str(obs_sel)); end
        checks++; if (first_fire !== 2) begin
            failures++; $display("FAIL basic_first_fire: got %0d want 2", first_fire); end
        checks++; if (bad_w !== 0 || sel_changes !== 0) begin
            failures++; $display("FAIL basic_pulse: got bad_w=%0d sel_changes=%0d want 0/0", bad_w, sel_changes); end
        checks++; if (!got_done || sf_obs !== 0 || busy1 !== 1'b1) begin
            failures++; $display("FAIL basic_done: got done=%0d sf=%0d busy1=%0d want 1/0/1", got_done, sf_obs, busy1); end
        checks++; if ({inv5, inv2, inv1} !== {8'd19, 8'd19, 8'd19}) begin
            failures++; $display("FAIL basic_inv: got %0d %0d %0d want 19 19 19", inv5, inv2, inv1); end
        checks++; if (done_after !== 1'b0) begin
            failures++; $display("FAIL basic_done_width: got %0d want 0", done_after); end
    endtask

    task automatic test_zero();
        model_payout(0, 4'b0, 0);
        run_payout(0, 4'b0, 2, 0, 1'b0, 50);
        checks++; if (done_cyc !== 2 || obs_sel.size() !== 0) begin
            failures++; $display("FAIL zero_done: got cyc=%0d fires=%0d want 2/0", done_cyc, obs_sel.size()); end
        checks++; if (busy1 !== 1'b1 || busy_at_done !== 1'b0) begin
            failures++; $display("FAIL zero_busy: got %0d/%0d want 1/0", busy1, busy_at_done); end
        checks++; if ({inv5, inv2, inv1} !== {8'(m_inv[3]), 8'(m_inv[2]), 8'(m_inv[1])}) begin
            failures++; $display("FAIL zero_inv: got %0d %0d %0d want %0d %0d %0d", inv5, inv2, inv1, m_inv[3], m_inv[2], m_inv[1]); end
    endtask

    task automatic test_refill();
        do_refill(2, 1);
        model_payout(2, 4'b0, 10);
        run_payout(2, 4'b0, 2, 10, 1'b0, 200);
        checks++; if (inv2 !== 8'd29 || int'(inv2) != m_inv[2]) begin
            failures++; $display("FAIL refill_net: got %0d want 29", inv2); end
        do_refill(1, 1);
        do_refill(1, 250);
        checks++; if (inv1 !== 8'd255) begin
            failures++; $display("FAIL refill_sat: got %0d want 255", inv1); end
        do_refill(0, 77);
        checks++; if ({inv5, inv2, inv1} !== {8'(m_inv[3]), 8'(m_inv[2]), 8'(m_inv[1])}) begin
            failures++; $display("FAIL refill_sel0: got %0d %0d %0d want %0d %0d %0d", inv5, inv2, inv1, m_inv[3], m_inv[2], m_inv[1]); end
    endtask

    task automatic test_shortage();
        // Jam coin 2 and coin 1 to empty them, then restock one of each.
        model_payout(3, 4'b0110, 0);
        run_payout(3, 4'b0110, 2, 0, 1'b0, 1500);
        checks++; if (!got_done || sfa_obs !== exp_sf || inv2 !== 8'd0 || inv1 !== 8'd0) begin
            failures++; $display("FAIL short_drain: got sfa=%0d inv2=%0d inv1=%0d want %0d/0/0", sfa_obs, inv2, inv1, exp_sf); end
        do_refill(2, 1);
        do_refill(1, 1);
        model_payout(4, 4'b0, 0);
        run_payout(4, 4'b0, 2, 0, 1'b0, 400);
        checks++; if (seq_str(obs_sel) != "2 1 ") begin
            failures++; $display("FAIL short_seq: got %s want 2 1", seq_str(obs_sel)); end
        checks++; if (sf_obs !== 1 || sfa_obs !== 1 || exp_sf != 1) begin
            failures++; $display("FAIL short_amt: got sf=%0d amt=%0d want 1/1", sf_obs, sfa_obs); end
        checks++; if (inv2 !== 8'd0 || inv1 !== 8'd0) begin
            failures++; $display("FAIL short_inv: got %0d %0d want 0 0", inv2, inv1); end
        @(negedge clk);
        checks++; if (shortfall !== 1'b1 || shortfall_amt !== 4'd1) begin
            failures++; $display("FAIL short_sticky: got %0d/%0d want 1/1", shortfall, shortfall_amt); end
    endtask

    task automatic test_reset_mid_fire();
        @(negedge clk);
        start = 1'b1; change_amt = 4'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++; if (hopper_fire !== 1'b1) begin
            failures++; $display("FAIL rst_pre_fire: got %0d want 1", hopper_fire); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (hopper_fire !== 1'b0 || busy !== 1'b0 || hopper_sel !== 2'd0) begin
            failures++; $display("FAIL rst_async: got fire=%0d busy=%0d sel=%0d want 0/0/0", hopper_fire, busy, hopper_sel); end
        checks++; if ({inv5, inv2, inv1} !== {8'd20, 8'd20, 8'd20} || fault !== 1'b0) begin
            failures++; $display("FAIL rst_inv: got %0d %0d %0d fault=%0d want 20 20 20 0", inv5, inv2, inv1, fault); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) m_inv[i] = 20;
        m_fault = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || hopper_fire !== 1'b0) begin
            failures++; $display("FAIL rst_idle: got busy=%0d fire=%0d want 0/0", busy, hopper_fire); end
        model_payout(7, 4'b0, 0);
        run_payout(7, 4'b0, 1, 0, 1'b0, 400);
        checks++; if (seq_str(obs_sel) != seq_str(exp_att) || !got_done || sf_obs !== 0) begin
            failures++; $display("FAIL rst_restart: got %s done=%0d want %s done=1", seq_str(obs_sel), got_done, seq_str(exp_att)); end
    endtask

    task automatic test_jam();
        model_payout(5, 4'b1000, 0);
        run_payout(5, 4'b1000, 2, 0, 1'b0, 2000);
        checks++; if (seq_str(obs_sel) != "3 2 2 1 ") begin
            failures++; $display("FAIL jam_seq: got %s want 3 2 2 1", seq_str(obs_sel)); end
        checks++; if (fault !== 1'b1 || inv5 !== 8'd0 || sf_obs !== 0) begin
            failures++; $display("FAIL jam_state: got fault=%0d inv5=%0d sf=%0d want 1/0/0", fault, inv5, sf_obs); end
        checks++; if ({inv2, inv1} !== {8'(m_inv[2]), 8'(m_inv[1])}) begin
            failures++; $display("FAIL jam_inv: got %0d %0d want %0d %0d", inv2, inv1, m_inv[2], m_inv[1]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int amt = $urandom_range(0, 15);
            int dly = $urandom_range(1, 4);
            bit [3:0] jam = ($urandom_range(0, 3) == 0) ? (4'b1 << $urandom_range(1, 3)) : 4'b0;
            bit poke = $urandom_range(0, 1) == 1;
            do_refill($urandom_range(0, 3), $urandom_range(0, 20));
            model_payout(amt, jam, 0);
            run_payout(amt, jam, dly, 0, poke, 2500);
            checks++; if (!got_done || seq_str(obs_sel) != seq_str(exp_att)) begin
                failures++; $display("FAIL rand_seq[%0d]: got %s done=%0d want %s", it, seq_str(obs_sel), got_done, seq_str(exp_att)); end
            checks++; if ({inv5, inv2, inv1} !== {8'(m_inv[3]), 8'(m_inv[2]), 8'(m_inv[1])}) begin
                failures++; $display("FAIL rand_inv[%0d]: got %0d %0d %0d want %0d %0d %0d", it, inv5, inv2, inv1, m_inv[3], m_inv[2], m_inv[1]); end
            checks++; if (sf_obs !== int'(exp_sf != 0) || sfa_obs !== exp_sf || fault !== m_fault) begin
                failures++; $display("FAIL rand_sf[%0d]: got sf=%0d amt=%0d fault=%0d want %0d/%0d/%0d", it, sf_obs, sfa_obs, fault, exp_sf != 0, exp_sf, m_fault); end
            checks++; if (bad_w !== 0 || sel_changes !== 0) begin
                failures++; $display("FAIL rand_pulse[%0d]: got bad_w=%0d sel_changes=%0d want 0/0", it, bad_w, sel_changes); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_refill();
        test_shortage();
        test_reset_mid_fire();
        test_jam();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
